// File: rtl/snd_cpu_bus_resp.sv
// Sound-CPU (8035) external bus responder: turns ALE/PSENn/RDn/WRn cycles into single-clock ROM/XDATA requests.
// Optional SNDBUS_ERRCNT_EN builds a saturating timeout/conflict counter on O_ERR_CNT.
module snd_cpu_bus_resp #(
    parameter int unsigned TIMEOUT = 16,
    parameter logic [7:0]  IDLE_DB = 8'hFF
) (
    input  logic        I_CLK,
    input  logic        I_RSTn,
    input  logic        I_ALE,
    input  logic        I_PSENn,
    input  logic        I_RDn,
    input  logic        I_WRn,
    input  logic [7:0]  I_CPU_DB,
    input  logic [7:0]  I_CPU_P2,
    output logic [7:0]  O_CPU_DB,
    output logic        O_ROM_REQ,
    output logic [11:0] O_ROM_A,
    input  logic        I_ROM_ACK,
    input  logic [7:0]  I_ROM_D,
    output logic        O_XRD_REQ,
    output logic        O_XWR_STB,
    output logic [15:0] O_XA,
    output logic [7:0]  O_XWD,
    input  logic        I_X_ACK,
    input  logic [7:0]  I_X_D,
    output logic        O_ERR,
    output logic [7:0]  O_ERR_CNT
);

    localparam int unsigned CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam int unsigned STB_PSEN = 0;
    localparam int unsigned STB_RD   = 1;
    localparam int unsigned STB_WR   = 2;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FREQ  = 3'd1;
    localparam logic [2:0] S_FWAIT = 3'd2;
    localparam logic [2:0] S_XREQ  = 3'd3;
    localparam logic [2:0] S_XWAIT = 3'd4;
    localparam logic [2:0] S_HOLD  = 3'd5;

    // strobe sampling and edge detect
    logic             ale_s_q, ale_s_d, ale_p_q, ale_p_d;
    logic [2:0]       stb_s_q, stb_s_d, stb_p_q, stb_p_d;
    logic [2:0]       arm_q, arm_d;
    logic [7:0]       db_s_q, db_s_d, db_p_q, db_p_d;
    logic [7:0]       p2_s_q, p2_s_d;

    logic [7:0]       lo_q, lo_d, hi_q, hi_d;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       data_q, data_d;
    logic             is_x_q, is_x_d;
    logic [7:0]       cpu_db_q, cpu_db_d;
    logic             rom_req_q, rom_req_d;
    logic             xrd_req_q, xrd_req_d;
    logic             xwr_stb_q, xwr_stb_d;
    logic [7:0]       xwd_q, xwd_d;
    logic             err_q, err_d;
    logic             ov_q, ov_d;

    logic             ale_fall, ale_rise;
    logic [2:0]       stb_fall, stb_rise;
    logic             ov;
    logic             wr_conflict;
    logic             psrd_conflict;
    logic             timeout_ev;
    logic             active_hi;
    logic             ack_sel;

    // A strobe only arms after being seen high twice, so one held low across reset never fires
    assign ale_fall    = ale_p_q & ~ale_s_q;
    assign ale_rise    = ~ale_p_q & ale_s_q;
    assign stb_fall    = stb_p_q & ~stb_s_q & arm_q;
    assign stb_rise    = ~stb_p_q & stb_s_q & arm_q;
    assign ov          = ~stb_s_q[STB_WR] & (~stb_s_q[STB_RD] | ~stb_s_q[STB_PSEN]) & arm_q[STB_WR];
    assign wr_conflict = ov & ~ov_q;
    assign active_hi   = is_x_q ? stb_s_q[STB_RD] : stb_s_q[STB_PSEN];
    assign ack_sel     = is_x_q ? I_X_ACK : I_ROM_ACK;

    always_ff @(posedge I_CLK) begin
        if (!I_RSTn) begin
            ale_s_q   <= 1'b0;
            ale_p_q   <= 1'b0;
            stb_s_q   <= 3'b111;
            stb_p_q   <= 3'b111;
            arm_q     <= 3'b000;
            db_s_q    <= 8'h00;
            db_p_q    <= 8'h00;
            p2_s_q    <= 8'h00;
            lo_q      <= 8'h00;
            hi_q      <= 8'h00;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            data_q    <= 8'h00;
            is_x_q    <= 1'b0;
            cpu_db_q  <= IDLE_DB;
            rom_req_q <= 1'b0;
            xrd_req_q <= 1'b0;
            xwr_stb_q <= 1'b0;
            xwd_q     <= 8'h00;
            err_q     <= 1'b0;
            ov_q      <= 1'b0;
        end else begin
            ale_s_q   <= ale_s_d;
            ale_p_q   <= ale_p_d;
            stb_s_q   <= stb_s_d;
            stb_p_q   <= stb_p_d;
            arm_q     <= arm_d;
            db_s_q    <= db_s_d;
            db_p_q    <= db_p_d;
            p2_s_q    <= p2_s_d;
            lo_q      <= lo_d;
            hi_q      <= hi_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            is_x_q    <= is_x_d;
            cpu_db_q  <= cpu_db_d;
            rom_req_q <= rom_req_d;
            xrd_req_q <= xrd_req_d;
            xwr_stb_q <= xwr_stb_d;
            xwd_q     <= xwd_d;
            err_q     <= err_d;
            ov_q      <= ov_d;
        end
    end

    always_comb begin
        ale_s_d       = I_ALE;
        ale_p_d       = ale_s_q;
        stb_s_d       = {I_WRn, I_RDn, I_PSENn};
        stb_p_d       = stb_s_q;
        arm_d         = arm_q | (stb_s_d & stb_s_q);
        db_s_d        = I_CPU_DB;
        db_p_d        = db_s_q;
        p2_s_d        = I_CPU_P2;
        lo_d          = lo_q;
        hi_d          = hi_q;
        state_d       = state_q;
        cnt_d         = cnt_q;
        data_d        = data_q;
        is_x_d        = is_x_q;
        xwd_d         = xwd_q;
        ov_d          = ov;
        timeout_ev    = 1'b0;
        psrd_conflict = 1'b0;

        if (ale_fall) begin
            lo_d = db_s_q;
            hi_d = p2_s_q;
        end

        // write data is the last sample taken while WRn was still low
        xwr_stb_d = stb_rise[STB_WR];
        if (stb_rise[STB_WR]) begin
            xwd_d = db_p_q;
        end

        if (ale_rise) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (stb_fall[STB_PSEN]) begin
                        state_d       = S_FREQ;
                        is_x_d        = 1'b0;
                        psrd_conflict = stb_fall[STB_RD];
                    end else if (stb_fall[STB_RD]) begin
                        state_d = S_XREQ;
                        is_x_d  = 1'b1;
                    end
                end
                S_FREQ, S_XREQ: begin
                    cnt_d = '0;
                    if (active_hi) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = is_x_q ? S_XWAIT : S_FWAIT;
                    end
                end
                S_FWAIT, S_XWAIT: begin
                    if (active_hi) begin
                        state_d = S_IDLE;
                    end else if (ack_sel) begin
                        data_d  = is_x_q ? I_X_D : I_ROM_D;
                        state_d = S_HOLD;
                    end else if (cnt_q == CNT_LAST) begin
                        data_d     = 8'hFF;
                        timeout_ev = 1'b1;
                        state_d    = S_HOLD;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_HOLD: begin
                    if (active_hi) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        rom_req_d = (state_d == S_FREQ);
        xrd_req_d = (state_d == S_XREQ);
        cpu_db_d  = (state_d == S_HOLD) ? data_d : IDLE_DB;
        err_d     = err_q | timeout_ev | psrd_conflict | wr_conflict;
    end

`ifdef SNDBUS_ERRCNT_EN
    // saturating count of timeouts and strobe conflicts
    logic [7:0] errcnt_q, errcnt_d;
    logic [1:0] err_inc;
    logic [8:0] errcnt_sum;

    always_comb begin
        err_inc    = 2'(timeout_ev) + 2'(psrd_conflict) + 2'(wr_conflict);
        errcnt_sum = 9'(errcnt_q) + 9'(err_inc);
        errcnt_d   = errcnt_sum[8] ? 8'hFF : errcnt_sum[7:0];
    end

    always_ff @(posedge I_CLK) begin
        if (!I_RSTn) begin
            errcnt_q <= 8'h00;
        end else begin
            errcnt_q <= errcnt_d;
        end
    end

    assign O_ERR_CNT = errcnt_q;
`else
    assign O_ERR_CNT = 8'h00;
`endif

    assign O_CPU_DB  = cpu_db_q;
    assign O_ROM_REQ = rom_req_q;
    assign O_ROM_A   = {hi_q[3:0], lo_q};
    assign O_XRD_REQ = xrd_req_q;
    assign O_XWR_STB = xwr_stb_q;
    assign O_XA      = {hi_q, lo_q};
    assign O_XWD     = xwd_q;
    assign O_ERR     = err_q;

endmodule

// File: tb/tb_snd_cpu_bus_resp.sv
// Directed bench for snd_cpu_bus_resp: fetch, MOVX read/write, timeout, conflicts, aborts and mid-cycle reset.
module tb_snd_cpu_bus_resp;

    logic        clk;
    logic        rst_n;
    logic        ale, psen_n, rd_n, wr_n;
    logic [7:0]  cpu_db, cpu_p2;
    logic        rom_ack, x_ack;
    logic [7:0]  rom_d, x_d;
    logic [7:0]  db_o;
    logic        rom_req, xrd_req, xwr_stb, err;
    logic [11:0] rom_a;
    logic [15:0] xa;
    logic [7:0]  xwd, err_cnt;

    int n_checks;
    int n_errors;
    int rom_pulses, xrd_pulses, xwr_pulses;

`ifdef SNDBUS_ERRCNT_EN
    localparam logic [7:0] EC1 = 8'h01;
    localparam logic [7:0] EC2 = 8'h02;
`else
    localparam logic [7:0] EC1 = 8'h00;
    localparam logic [7:0] EC2 = 8'h00;
`endif

    snd_cpu_bus_resp #(.TIMEOUT(16), .IDLE_DB(8'hFF)) dut (
        .I_CLK     (clk),
        .I_RSTn    (rst_n),
        .I_ALE     (ale),
        .I_PSENn   (psen_n),
        .I_RDn     (rd_n),
        .I_WRn     (wr_n),
        .I_CPU_DB  (cpu_db),
        .I_CPU_P2  (cpu_p2),
        .O_CPU_DB  (db_o),
        .O_ROM_REQ (rom_req),
        .O_ROM_A   (rom_a),
        .I_ROM_ACK (rom_ack),
        .I_ROM_D   (rom_d),
        .O_XRD_REQ (xrd_req),
        .O_XWR_STB (xwr_stb),
        .O_XA      (xa),
        .O_XWD     (xwd),
        .I_X_ACK   (x_ack),
        .I_X_D     (x_d),
        .O_ERR     (err),
        .O_ERR_CNT (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // advance n clocks, sampling 1 time unit after each rising edge
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (rom_req)  rom_pulses++;
            if (xrd_req)  xrd_pulses++;
            if (xwr_stb)  xwr_pulses++;
        end
    endtask

    task automatic clear_pulses();
        rom_pulses = 0;
        xrd_pulses = 0;
        xwr_pulses = 0;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        ale     = 1'b0;
        psen_n  = 1'b1;
        rd_n    = 1'b1;
        wr_n    = 1'b1;
        rom_ack = 1'b0;
        x_ack   = 1'b0;
        step(3);
        rst_n = 1'b1;
        step(3);
    endtask

    task automatic ale_latch(input logic [7:0] lo, input logic [7:0] hi);
        cpu_db = lo;
        cpu_p2 = hi;
        ale    = 1'b1;
        step(2);
        ale = 1'b0;
        step(3);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        cpu_db   = 8'h00;
        cpu_p2   = 8'h00;
        rom_d    = 8'h00;
        x_d      = 8'h00;
        clear_pulses();
        do_reset();

        check("rst_db",     32'(db_o),    32'h00FF);
        check("rst_romreq", 32'(rom_req), 32'h0);
        check("rst_xa",     32'(xa),      32'h0);
        check("rst_xwd",    32'(xwd),     32'h0);
        check("rst_err",    32'(err),     32'h0);
        check("rst_errcnt", 32'(err_cnt), 32'h0);

        // program fetch
        ale_latch(8'h34, 8'h05);
        check("fetch_addr", 32'(rom_a), 32'h534);
        clear_pulses();
        psen_n = 1'b0;
        step(2);
        check("fetch_req", 32'(rom_req), 32'h1);
        step(1);
        rom_ack = 1'b1;
        rom_d   = 8'hA7;
        step(1);
        rom_ack = 1'b0;
        check("fetch_data", 32'(db_o), 32'hA7);
        step(3);
        check("fetch_hold",  32'(db_o),       32'hA7);
        check("fetch_1req",  32'(rom_pulses), 32'h1);
        psen_n = 1'b1;
        step(1);
        check("fetch_hold_edge", 32'(db_o), 32'hA7);
        step(1);
        check("fetch_release", 32'(db_o), 32'hFF);
        check("fetch_noerr",   32'(err),  32'h0);

        // MOVX read
        ale_latch(8'h80, 8'h9C);
        check("xrd_addr", 32'(xa), 32'h9C80);
        clear_pulses();
        rd_n = 1'b0;
        step(2);
        check("xrd_req", 32'(xrd_req), 32'h1);
        step(1);
        x_ack = 1'b1;
        x_d   = 8'h3C;
        step(1);
        x_ack = 1'b0;
        check("xrd_data", 32'(db_o), 32'h3C);
        step(3);
        check("xrd_hold",    32'(db_o),       32'h3C);
        check("xrd_1req",    32'(xrd_pulses), 32'h1);
        check("xrd_norom",   32'(rom_pulses), 32'h0);
        rd_n = 1'b1;
        step(2);
        check("xrd_release", 32'(db_o), 32'hFF);

        // external write: DB changes as WRn rises, so the latched value must be the low-phase one
        ale_latch(8'h10, 8'h00);
        clear_pulses();
        cpu_db = 8'h5A;
        wr_n   = 1'b0;
        step(4);
        cpu_db = 8'h00;
        wr_n   = 1'b1;
        step(2);
        check("wr_stb",  32'(xwr_stb), 32'h1);
        check("wr_xa",   32'(xa),      32'h0010);
        check("wr_xwd",  32'(xwd),     32'h5A);
        step(3);
        check("wr_1stb", 32'(xwr_pulses), 32'h1);
        check("wr_noerr", 32'(err),       32'h0);

        // fetch timeout: error appears 17 clocks after the request, not 16
        clear_pulses();
        psen_n = 1'b0;
        step(2);
        check("tmo_req", 32'(rom_req), 32'h1);
        step(16);
        check("tmo_not_yet", 32'(err), 32'h0);
        step(1);
        check("tmo_err",    32'(err),     32'h1);
        check("tmo_db",     32'(db_o),    32'hFF);
        check("tmo_errcnt", 32'(err_cnt), 32'(EC1));
        rom_ack = 1'b1;
        rom_d   = 8'h12;
        step(1);
        rom_ack = 1'b0;
        check("hold_ack_ignored", 32'(db_o), 32'hFF);
        psen_n = 1'b1;
        step(2);
        check("tmo_release", 32'(db_o), 32'hFF);

        // PSENn and RDn fall together
        do_reset();
        clear_pulses();
        psen_n = 1'b0;
        rd_n   = 1'b0;
        step(6);
        check("conf_rom",    32'(rom_pulses), 32'h1);
        check("conf_xrd",    32'(xrd_pulses), 32'h0);
        check("conf_err",    32'(err),        32'h1);
        check("conf_errcnt", 32'(err_cnt),    32'(EC1));
        psen_n = 1'b1;
        rd_n   = 1'b1;
        step(3);

        // PSENn rises before ack; late ack ignored, no new error
        psen_n = 1'b0;
        step(2);
        psen_n = 1'b1;
        step(2);
        rom_ack = 1'b1;
        rom_d   = 8'hA5;
        step(1);
        rom_ack = 1'b0;
        step(2);
        check("abort_db",     32'(db_o),    32'hFF);
        check("abort_errcnt", 32'(err_cnt), 32'(EC1));

        // ALE rising mid-fetch aborts it
        clear_pulses();
        psen_n = 1'b0;
        step(3);
        ale = 1'b1;
        step(2);
        rom_ack = 1'b1;
        rom_d   = 8'h66;
        step(1);
        rom_ack = 1'b0;
        ale     = 1'b0;
        step(2);
        check("ale_abort_db",  32'(db_o),       32'hFF);
        check("ale_abort_req", 32'(rom_pulses), 32'h1);
        psen_n = 1'b1;
        step(3);

        // write while a read is in progress
        clear_pulses();
        rd_n = 1'b0;
        step(2);
        cpu_db = 8'h77;
        wr_n   = 1'b0;
        step(2);
        wr_n = 1'b1;
        step(3);
        check("wrconf_stb",    32'(xwr_pulses), 32'h1);
        check("wrconf_xwd",    32'(xwd),        32'h77);
        check("wrconf_errcnt", 32'(err_cnt),    32'(EC2));
        rd_n = 1'b1;
        step(3);

        // reset during FWAIT with RDn held low through release
        psen_n = 1'b0;
        step(4);
        rd_n = 1'b0;
        step(1);
        rst_n = 1'b0;
        step(2);
        psen_n = 1'b1;
        step(1);
        rst_n = 1'b1;
        step(1);
        check("mid_rst_db",     32'(db_o),    32'hFF);
        check("mid_rst_roma",   32'(rom_a),   32'h0);
        check("mid_rst_xa",     32'(xa),      32'h0);
        check("mid_rst_xwd",    32'(xwd),     32'h0);
        check("mid_rst_err",    32'(err),     32'h0);
        check("mid_rst_errcnt", 32'(err_cnt), 32'h0);
        clear_pulses();
        step(5);
        check("mid_rst_noxrd", 32'(xrd_pulses), 32'h0);
        check("mid_rst_norom", 32'(rom_pulses), 32'h0);
        rd_n = 1'b1;
        step(3);
        rd_n = 1'b0;
        step(2);
        check("mid_rst_fresh", 32'(xrd_pulses), 32'h1);
        rd_n = 1'b1;
        step(3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/snd_cpu_bus_resp.md
Name: snd_cpu_bus_resp

Overview:
- Bus responder on the external side of the sound CPU (8035 core) in the DK Jr sound section.
- Decodes the CPU's multiplexed bus cycles (ALE, PSENn, RDn, WRn, DB, P2) and turns them into clean single-clock request/ack transactions toward program ROM and external data (sound sample ROM / latches).
- Returns read data on the CPU's DB input.
- Runs on the same clock as the CPU core and samples all CPU strobes synchronously.

Parameters:
- TIMEOUT, 16, max clocks to wait for a ROM/XDATA ack before forcing data 8'hFF and flagging an error.
- IDLE_DB, 8'hFF, value driven on O_CPU_DB when no read cycle is active (pull-up emulation).

Ports:
- I_CLK  in  1  system clock, the same clock that drives the CPU core.
- I_RSTn  in  1  synchronous active-low reset.
- I_ALE  in  1  CPU ALE.
- I_PSENn  in  1  CPU program-store enable.
- I_RDn  in  1  CPU external read strobe.
- I_WRn  in  1  CPU external write strobe.
- I_CPU_DB  in  8  CPU DB output (address low byte / write data).
- I_CPU_P2  in  8  CPU port 2 output (address high / bank bits).
- O_CPU_DB  out  8  read data to CPU DB input.
- O_ROM_REQ  out  1  one-clock program fetch request.
- O_ROM_A  out  12  program address {P2[3:0], low byte}.
- I_ROM_ACK  in  1  ROM data valid, one clock.
- I_ROM_D  in  8  ROM data.
- O_XRD_REQ  out  1  one-clock external data read request.
- O_XWR_STB  out  1  one-clock external write strobe.
- O_XA  out  16  external data address {P2[7:0], low byte}.
- O_XWD  out  8  external write data.
- I_X_ACK  in  1  external read data valid.
- I_X_D  in  8  external read data.
- O_ERR  out  1  sticky error flag.
- O_ERR_CNT  out  8  timeout/conflict count (see Optional Feature).

Behaviour:
- All strobes are registered once. Edges are detected from the current sample vs the previous sample. Detection latency is 1 clock.
- Address latch:
  - On an ALE falling edge, latch lo <= I_CPU_DB and hi <= I_CPU_P2.
  - O_ROM_A and O_XA update on the following clock and hold until the next ALE fall.
- FSM states: IDLE, FREQ, FWAIT, XREQ, XWAIT, HOLD.
  - IDLE, PSENn falling edge -> FREQ. Assert O_ROM_REQ for exactly 1 clock, then go to FWAIT.
  - IDLE, RDn falling edge -> XREQ. Assert O_XRD_REQ for exactly 1 clock, then go to XWAIT.
  - FWAIT/XWAIT, matching ack -> capture I_ROM_D / I_X_D into the data register and go to HOLD.
  - FWAIT/XWAIT, TIMEOUT clocks elapsed with no ack -> data register <= 8'hFF, set O_ERR, go to HOLD.
  - HOLD: O_CPU_DB = data register until the active strobe (PSENn or RDn) deasserts, then IDLE with O_CPU_DB = IDLE_DB.
  - FREQ/FWAIT/XREQ/XWAIT, strobe deasserts before ack -> abort to IDLE. A late ack is ignored. No error is flagged.
  - Any state, ALE rising -> abort to IDLE. No strobe is generated.
- Write path:
  - Writes do not use the FSM.
  - On a WRn rising edge, latch O_XWD <= I_CPU_DB, sampled on the last clock WRn was low.
  - O_XWR_STB pulses for 1 clock, with O_XA valid that same clock.
- Simultaneous events:
  - PSENn and RDn falling on the same clock: PSEN wins, O_ERR is set, RDn is ignored until the next IDLE.
  - WRn low while RDn or PSENn is low: the write strobe is still generated and O_ERR is set.
- Ack pulses arriving in IDLE or HOLD are ignored.
- Reset (synchronous, any state, mid-cycle allowed) produces:
  - FSM = IDLE.
  - O_CPU_DB = IDLE_DB.
  - All REQ/STB outputs = 0.
  - O_ROM_A = 0, O_XA = 0, O_XWD = 0.
  - O_ERR = 0, O_ERR_CNT = 0.
  - Edge-detect registers preset to the inactive level: ALE = 0, strobes = 1. A strobe already low at reset release does not trigger a cycle.
- The timeout counter is clog2(TIMEOUT+1) bits wide and clears on entry to FWAIT or XWAIT.

Optional Feature:
- SNDBUS_ERRCNT_EN defined:
  - O_ERR_CNT is an 8-bit saturating counter, stopping at 8'hFF.
  - It increments once per timeout or per strobe conflict.
  - It clears only on reset.
- SNDBUS_ERRCNT_EN not defined:
  - O_ERR_CNT is tied to 8'h00 and no counter logic is built.
  - O_ERR behaviour is unchanged.

Test Plan:
- Program fetch: ALE falls with DB=8'h34 and P2=8'h05; PSENn falls; ROM acks 3 clocks later with 8'hA7 -> O_ROM_A=12'h534, exactly one O_ROM_REQ pulse, O_CPU_DB=8'hA7 until PSENn rises, then 8'hFF.
- MOVX read: ALE latches 8'h80 with P2=8'h9C; RDn falls; X ack with 8'h3C -> O_XA=16'h9C80, one O_XRD_REQ pulse, O_CPU_DB=8'h3C during RDn low.
- Write: ALE latches 8'h10 with P2=8'h00; WRn low 4 clocks with DB=8'h5A -> a single O_XWR_STB one clock after WRn rises, O_XA=16'h0010, O_XWD=8'h5A.
- Timeout: PSENn held low with no ack, TIMEOUT=16 -> O_CPU_DB=8'hFF at clock 17 after the request, O_ERR=1, O_ERR_CNT=1 with the macro defined, 0 without.
- Conflict and abort:
  - PSENn and RDn fall together -> only O_ROM_REQ fires and O_ERR=1.
  - Separately: PSENn rises before ack, then ack arrives -> O_CPU_DB stays 8'hFF.
- Reset mid-cycle: assert I_RSTn=0 in FWAIT with RDn held low through release -> all outputs at reset values and no request until a fresh falling edge.
